// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and flag bit positions for the ALU op sequencer
package alu_seq_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_COMP = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  // Flag register layout is {C,AC,Z,S}
  localparam int FLAG_C  = 3;
  localparam int FLAG_AC = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_S  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 4x8 register file, two async read ports, one sync write port
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter logic [DATA_W-1:0] REG_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= REG_INIT;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command/response sequencer that issues register-file operations to an external ALU
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [2:0] CmdOpcode,
  input  logic       CmdLoad,
  input  logic [1:0] CmdDst,
  input  logic [1:0] CmdSrcA,
  input  logic [1:0] CmdSrcB,
  input  logic       CmdImmSel,
  input  logic [7:0] CmdImm,
  output logic [2:0] AluOpcode,
  output logic [7:0] AluOp1,
  output logic [7:0] AluOp2,
  input  logic [7:0] AluRes,
  input  logic       AluC,
  input  logic       AluAC,
  input  logic       AluZ,
  input  logic       AluS,
  output logic       RspValid,
  input  logic       RspReady,
  output logic [7:0] RspData,
  output logic [3:0] RspFlags,
  output logic       Busy
);

  state_t     state, next_state;
  logic       accept;
  logic [1:0] dst_q;
  logic [3:0] flags;
  logic [7:0] rd_a, rd_b;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;

  assign accept = CmdValid && CmdReady;

  // Loads write at the accept edge; ALU results write at the closing edge of ISSUE
  assign rf_we    = (accept && CmdLoad) || (state == ST_ISSUE);
  assign rf_waddr = (state == ST_ISSUE) ? dst_q  : CmdDst;
  assign rf_wdata = (state == ST_ISSUE) ? AluRes : CmdImm;

  alu_seq_regfile #(
    .REG_INIT (REG_INIT)
  ) u_regfile (
    .clk     (Clk),
    .rst     (Rst),
    .raddr_a (CmdSrcA),
    .rdata_a (rd_a),
    .raddr_b (CmdSrcB),
    .rdata_b (rd_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    CmdReady   = 1'b0;
    RspValid   = 1'b0;
    case (state)
      ST_IDLE: begin
        CmdReady = 1'b1;
        if (CmdValid) next_state = CmdLoad ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: next_state = ST_RESP;
      ST_RESP: begin
        RspValid = 1'b1;
        if (RspReady) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign Busy     = (state != ST_IDLE);
  assign RspFlags = flags;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      AluOpcode <= 3'd0;
      AluOp1    <= 8'd0;
      AluOp2    <= 8'd0;
      RspData   <= 8'd0;
      flags     <= 4'd0;
      dst_q     <= 2'd0;
    end else begin
      if (accept) begin
        if (CmdLoad) begin
          RspData <= CmdImm;
        end else begin
          AluOpcode <= CmdOpcode;
          AluOp1    <= rd_a;
          AluOp2    <= CmdImmSel ? CmdImm : rd_b;
          dst_q     <= CmdDst;
        end
      end
      if (state == ST_ISSUE) begin
        RspData <= AluRes;
        // Logic ops only touch Z so carries from a prior ADD/SUB survive
        if (is_arith(AluOpcode)) flags <= {AluC, AluAC, AluZ, AluS};
        else                     flags[FLAG_Z] <= AluZ;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench with a team ALU and a register/flag reference model
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam logic [7:0] REG_INIT = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_load, cmd_imm_sel;
  logic [2:0] cmd_opcode;
  logic [1:0] cmd_dst, cmd_src_a, cmd_src_b;
  logic [7:0] cmd_imm;
  logic [2:0] alu_opcode;
  logic [7:0] alu_op1, alu_op2, alu_res;
  logic       alu_c, alu_ac, alu_z, alu_s;
  logic       rsp_valid, rsp_ready, busy;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_regs [4];
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  alu_op_sequencer #(.REG_INIT(REG_INIT)) dut (
    .Clk(clk), .Rst(rst),
    .CmdValid(cmd_valid), .CmdReady(cmd_ready), .CmdOpcode(cmd_opcode), .CmdLoad(cmd_load),
    .CmdDst(cmd_dst), .CmdSrcA(cmd_src_a), .CmdSrcB(cmd_src_b),
    .CmdImmSel(cmd_imm_sel), .CmdImm(cmd_imm),
    .AluOpcode(alu_opcode), .AluOp1(alu_op1), .AluOp2(alu_op2),
    .AluRes(alu_res), .AluC(alu_c), .AluAC(alu_ac), .AluZ(alu_z), .AluS(alu_s),
    .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data), .RspFlags(rsp_flags),
    .Busy(busy)
  );

  // Team 8-bit ALU: returns {res, C, AC, Z, S}; C/AC mean borrow on SUB
  function automatic logic [11:0] team_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [4:0] n;
    logic [7:0] r;
    logic c, ac;
    c = 1'b0; ac = 1'b0; w = 9'd0; n = 5'd0;
    case (op)
      3'b000: begin
        w = {1'b0, a} + {1'b0, b};
        n = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        r = w[7:0]; c = w[8]; ac = n[4];
      end
      3'b001: begin r = a - b; c = (a < b); ac = (a[3:0] < b[3:0]); end
      3'b010: r = ~a;
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: r = ~(a & b);
      3'b110: r = ~(a | b);
      default: r = a ^ b;
    endcase
    return {r, c, ac, (r == 8'd0), r[7]};
  endfunction

  always_comb {alu_res, alu_c, alu_ac, alu_z, alu_s} = team_alu(alu_opcode, alu_op1, alu_op2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = REG_INIT;
    m_flags = 4'd0;
  endtask

  // Issue one command, check the ALU drive and response against the model, then retire it
  task automatic run_cmd(input logic load, input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] a, input logic [1:0] b, input logic isel,
                         input logic [7:0] imm, input int hold,
                         output logic [7:0] got_data, output logic [3:0] got_flags);
    logic [7:0]  op2, exp_data;
    logic [11:0] r;
    wait_ready();
    cmd_load = load; cmd_opcode = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b;
    cmd_imm_sel = isel; cmd_imm = imm; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (load) begin
      m_regs[dst] = imm;
      exp_data = imm;
      check("load_rsp_valid_n1", rsp_valid, 1);
    end else begin
      op2 = isel ? imm : m_regs[b];
      check("issue_rsp_valid_low", rsp_valid, 0);
      check("issue_busy", busy, 1);
      check("issue_alu_opcode", alu_opcode, op);
      check("issue_alu_op1", alu_op1, m_regs[a]);
      check("issue_alu_op2", alu_op2, op2);
      r = team_alu(op, m_regs[a], op2);
      exp_data = r[11:4];
      if (op == OP_ADD || op == OP_SUB) m_flags = r[3:0];
      else m_flags[FLAG_Z] = r[1];
      m_regs[dst] = exp_data;
      @(posedge clk); #1;
      check("alu_rsp_valid_n2", rsp_valid, 1);
    end
    got_data = rsp_data;
    got_flags = rsp_flags;
    check("rsp_data", rsp_data, exp_data);
    check("rsp_flags", rsp_flags, m_flags);
    check("resp_cmd_ready_low", cmd_ready, 0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_load = 1'($urandom); cmd_opcode = 3'($urandom);
      cmd_dst = 2'($urandom); cmd_src_a = 2'($urandom); cmd_src_b = 2'($urandom);
      cmd_imm_sel = 1'($urandom); cmd_imm = 8'($urandom);
      @(posedge clk); #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, exp_data);
      check("hold_rsp_flags", rsp_flags, m_flags);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("retire_busy", busy, 0);
    check("retire_rsp_valid", rsp_valid, 0);
    check("retire_cmd_ready", cmd_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_flags"}, rsp_flags, 0);
    check({tag, "_alu_opcode"}, alu_opcode, 0);
    check({tag, "_alu_op1"}, alu_op1, 0);
    check({tag, "_alu_op2"}, alu_op2, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] f;
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_opcode = 3'd0; cmd_dst = 2'd0;
    cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm_sel = 1'b0; cmd_imm = 8'd0; rsp_ready = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_cmd(1, OP_ADD, 2'd0, 2'd0, 2'd0, 0, 8'h0F, 0, d, f);
    run_cmd(1, OP_ADD, 2'd1, 2'd0, 2'd0, 0, 8'h01, 0, d, f);
    run_cmd(0, OP_ADD, 2'd2, 2'd0, 2'd1, 0, 8'h00, 0, d, f);
    check("add_0f_01_data", d, 8'h10);
    check("add_0f_01_flags", f, 4'b0100);

    run_cmd(1, OP_ADD, 2'd0, 2'd0, 2'd0, 0, 8'hFF, 0, d, f);
    run_cmd(0, OP_ADD, 2'd0, 2'd0, 2'd0, 1, 8'h01, 0, d, f);
    check("add_ff_01_data", d, 8'h00);
    check("add_ff_01_flags", f, 4'b1110);
    run_cmd(0, OP_AND, 2'd1, 2'd0, 2'd0, 1, 8'h00, 0, d, f);
    check("and_hold_cflags_data", d, 8'h00);
    check("and_hold_cflags_flags", f, 4'b1110);

    run_cmd(1, OP_ADD, 2'd0, 2'd0, 2'd0, 0, 8'h10, 0, d, f);
    run_cmd(0, OP_SUB, 2'd3, 2'd0, 2'd0, 1, 8'h01, 0, d, f);
    check("sub_10_01_data", d, 8'h0F);
    check("sub_10_01_flags", f, 4'b0100);

    run_cmd(0, OP_XOR, 2'd2, 2'd3, 2'd0, 0, 8'h00, 5, d, f);
    run_cmd(0, OP_ADD, 2'd0, 2'd0, 2'd0, 0, 8'h00, 0, d, f);
    run_cmd(0, OP_ADD, 2'd1, 2'd0, 2'd1, 0, 8'h00, 0, d, f);

    // Abort an operation with a reset pulse in the middle of ISSUE
    run_cmd(1, OP_ADD, 2'd1, 2'd0, 2'd0, 0, 8'h5A, 0, d, f);
    wait_ready();
    cmd_load = 1'b0; cmd_opcode = OP_OR; cmd_dst = 2'd2; cmd_src_a = 2'd1;
    cmd_imm_sel = 1'b1; cmd_imm = 8'hA5; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_rsp", rsp_valid, 0);
    end
    for (int i = 0; i < 4; i++) run_cmd(0, OP_ADD, 2'(i), 2'(i), 2'd0, 1, 8'h00, 0, d, f);
    run_cmd(0, OP_ADD, 2'd0, 2'd1, 2'd2, 1, 8'h3C, 0, d, f);

    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom_range(0, 3) == 0), 3'($urandom), 2'($urandom), 2'($urandom),
              2'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3), d, f);
    end
    for (int i = 0; i < 4; i++) run_cmd(0, OP_OR, 2'(i), 2'(i), 2'd0, 1, 8'h00, 0, d, f);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: REG_INIT, 8'h00, reset value of every register-file entry.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-high.
REQ-004 CmdValid/CmdReady  in/out  1/1  command handshake; transfer when both high at a Clk edge.
REQ-005 CmdOpcode in 3 (ADD 000, SUB 001, COMP 010, AND 011, OR 100, NAND 101, NOR 110, XOR 111); CmdLoad in 1 (1 = load immediate, no ALU op).
REQ-006 CmdDst, CmdSrcA, CmdSrcB  in  2 each  register indices; CmdImmSel in 1 (1 = Op2 from CmdImm); CmdImm in 8.
REQ-007 AluOpcode out 3, AluOp1 out 8, AluOp2 out 8  drive the team's 8-bit combinational ALU.
REQ-008 AluRes in 8; AluC, AluAC, AluZ, AluS in 1 each  ALU result and flags.
REQ-009 RspValid out 1, RspReady in 1, RspData out 8, RspFlags out 4 ({C,AC,Z,S})  response handshake.
REQ-010 Busy  out  1  high whenever state is not IDLE.

Function
REQ-011 Block SHALL hold a 4 x 8-bit register file and a 4-bit flag register {C,AC,Z,S}.
REQ-012 FSM states SHALL be IDLE, ISSUE, RESP; CmdReady = 1 only in IDLE.
REQ-013 IDLE: on handshake, capture all Cmd fields; CmdLoad=1 -> RESP, else -> ISSUE.
REQ-014 Load: at the accept edge, reg[CmdDst] <= CmdImm; RspData = CmdImm; flag register unchanged.
REQ-015 Entering ISSUE: registered AluOpcode = captured opcode, AluOp1 = reg[SrcA], AluOp2 = ImmSel ? Imm : reg[SrcB]; operands stable for the whole ISSUE cycle.
REQ-016 ISSUE lasts exactly one cycle; at its closing edge AluRes is written to reg[Dst] and RspData, state -> RESP.
REQ-017 ADD/SUB: flag register SHALL take AluC, AluAC, AluZ, AluS verbatim (C/AC = borrow on SUB).
REQ-018 COMP, AND, OR, NAND, NOR, XOR: only Z updated (from AluZ); C, AC, S held.
REQ-019 RESP: RspValid=1, RspData/RspFlags stable until RspReady; on RspValid&RspReady -> IDLE next edge.
REQ-020 Latency: ALU command accepted at edge N -> RspValid high from edge N+2; load -> from N+1; max throughput one ALU command per 3 cycles.
REQ-021 Dst equal to SrcA or SrcB allowed; operands read pre-write values; next command sees written value.
REQ-022 AluOpcode/AluOp1/AluOp2 SHALL hold last driven values in IDLE and RESP.
REQ-023 CmdValid while not in IDLE SHALL be ignored (no capture, no side effect).

Reset
REQ-024 Rst high SHALL immediately force: state IDLE, registers REG_INIT, flags 0, RspValid 0, RspData 0, RspFlags 0, AluOpcode/AluOp1/AluOp2 0, Busy 0, CmdReady 1.
REQ-025 Rst during ISSUE or RESP SHALL abort the operation: no register write, no response issued.

Structure
REQ-026 Shared package alu_seq_pkg SHALL hold opcode constants, FSM state enum, flag bit positions.
REQ-027 Register file SHALL be sub-module alu_seq_regfile (4x8, 2 async read ports, 1 sync write port, async reset to REG_INIT).
REQ-028 ALU SHALL remain external; bench instantiates the team ALU wired to Alu* ports.

Verification
REQ-029 LOAD r0=0x0F, LOAD r1=0x01, ADD r2=r0+r1 -> RspData 0x10, RspFlags C0 AC1 Z1? no: C=0 AC=1 Z=0 S=0; r2=0x10.
REQ-030 r0=0xFF, ADD r0=r0+imm 0x01 -> RspData 0x00, C=1, AC=1, Z=1, S=0; RspValid at edge N+2.
REQ-031 r0=0x10, SUB r3=r0-imm 0x01 -> RspData 0x0F, C=0, AC=1, Z=0, S=0.
REQ-032 After REQ-030 flags, AND r1=r0&imm 0x00 -> RspData 0x00, Z=1, C=1, AC=1, S=0 held.
REQ-033 RspReady low 5 cycles in RESP -> RspValid, RspData, RspFlags stable, CmdReady 0, concurrent CmdValid not accepted.
REQ-034 Rst pulse during ISSUE -> all outputs reset values, registers REG_INIT, no response, next command executes normally.
